cam_ctrl: RTL

Request-driven controller for a DEPTH x WIDTH binary CAM built from the team's enabled compare flip-flop cells. It sits directly upstream of the cell array and drives each cell's data, write-enable, search-enable and search-key inputs. It also sits downstream of the array: it consumes every cell's match output, reduces the matches per row, masks them with a per-row valid bit, and priority-encodes the result. Clients reach the CAM only through its valid/ready request and response channels.

---
 rtl/cam_ctrl_if.sv | 29 ++
 rtl/cam_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/cam_ctrl_if.sv
// Request/response channel bundle between a CAM client (master) and cam_ctrl (slave).
// Width parameters must match the cam_ctrl instance the bundle is connected to.
interface cam_ctrl_if #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) ();
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [WIDTH-1:0]  req_key;

    logic              resp_valid;
    logic              resp_ready;
    logic              resp_hit;
    logic [ADDR_W-1:0] resp_addr;
    logic              resp_multi;

    modport master (
        output req_valid, req_op, req_addr, req_key, resp_ready,
        input  req_ready, resp_valid, resp_hit, resp_addr, resp_multi
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_key, resp_ready,
        output req_ready, resp_valid, resp_hit, resp_addr, resp_multi
    );
endinterface

// File: rtl/cam_ctrl.sv
// Controller for a DEPTH x WIDTH binary CAM: drives the cell array, reduces and
// masks its per-cell matches, and priority-encodes the result onto a response channel.
module cam_ctrl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    cam_ctrl_if.slave              bus,
    output logic [WIDTH-1:0]       o_cell_data,
    output logic [DEPTH-1:0]       o_cell_we,
    output logic                   o_cell_se,
    output logic [WIDTH-1:0]       o_cell_key,
    input  logic [DEPTH*WIDTH-1:0] i_cell_match,
    output logic [DEPTH-1:0]       o_valid
);

    localparam logic [1:0] OP_SEARCH = 2'b00;
    localparam logic [1:0] OP_WRITE  = 2'b01;
    localparam logic [1:0] OP_INVAL  = 2'b10;
    localparam logic [1:0] OP_CLEAR  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        SEARCH,
        EVAL,
        WRITE,
        RESP
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W-1:0] r_addr;
    logic [WIDTH-1:0]  r_key;
    logic [DEPTH-1:0]  r_valid;
    logic [DEPTH-1:0]  r_row_match;
    logic              r_resp_hit;
    logic [ADDR_W-1:0] r_resp_addr;
    logic              r_resp_multi;

    logic              w_accept;
    logic [DEPTH-1:0]  w_row_hit;
    logic [ADDR_W-1:0] w_enc_addr;
    logic              w_multi;

    assign w_accept = bus.req_valid && (r_state == IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Invalidate and clear finish on the acceptance edge, so they jump straight to RESP.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    case (bus.req_op)
                        OP_SEARCH: w_next_state = SEARCH;
                        OP_WRITE:  w_next_state = WRITE;
                        default:   w_next_state = RESP;
                    endcase
                end
            end
            SEARCH:  w_next_state = EVAL;
            EVAL:    w_next_state = RESP;
            WRITE:   w_next_state = RESP;
            RESP: begin
                if (bus.resp_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready  = (r_state == IDLE);
        bus.resp_valid = (r_state == RESP);
        bus.resp_hit   = r_resp_hit;
        bus.resp_addr  = r_resp_addr;
        bus.resp_multi = r_resp_multi;
        o_cell_se      = 1'b0;
        o_cell_key     = '0;
        o_cell_we      = '0;
        o_cell_data    = '0;
        if (r_state == SEARCH) begin
            o_cell_se  = 1'b1;
            o_cell_key = r_key;
        end
        if (r_state == WRITE) begin
            o_cell_we   = DEPTH'(1) << r_addr;
            o_cell_data = r_key;
        end
    end

    // A row hits only when every one of its cells matches the broadcast key.
    always_comb begin
        w_row_hit = '0;
        for (int r = 0; r < DEPTH; r++) begin
            w_row_hit[r] = &i_cell_match[r*WIDTH +: WIDTH];
        end
    end

    // Scanning downward lets the lowest matching row overwrite any higher one.
    always_comb begin
        w_enc_addr = '0;
        for (int r = DEPTH - 1; r >= 0; r--) begin
            if (r_row_match[r]) begin
                w_enc_addr = ADDR_W'(r);
            end
        end
        w_multi = |(r_row_match & (r_row_match - DEPTH'(1)));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr       <= '0;
            r_key        <= '0;
            r_valid      <= '0;
            r_row_match  <= '0;
            r_resp_hit   <= 1'b0;
            r_resp_addr  <= '0;
            r_resp_multi <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_addr <= bus.req_addr;
                        r_key  <= bus.req_key;
                        if (bus.req_op == OP_INVAL) begin
                            r_valid[bus.req_addr] <= 1'b0;
                            r_resp_hit   <= 1'b0;
                            r_resp_addr  <= bus.req_addr;
                            r_resp_multi <= 1'b0;
                        end else if (bus.req_op == OP_CLEAR) begin
                            r_valid      <= '0;
                            r_resp_hit   <= 1'b0;
                            r_resp_addr  <= '0;
                            r_resp_multi <= 1'b0;
                        end
                    end
                end
                SEARCH: begin
                    r_row_match <= w_row_hit & r_valid;
                end
                EVAL: begin
                    r_resp_hit   <= |r_row_match;
                    r_resp_addr  <= w_enc_addr;
                    r_resp_multi <= w_multi;
                end
                WRITE: begin
                    r_valid[r_addr] <= 1'b1;
                    r_resp_hit      <= 1'b1;
                    r_resp_addr     <= r_addr;
                    r_resp_multi    <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign o_valid = r_valid;

endmodule
